// File: rtl/wb_arbiter.sv
// Merges ALU results and queued load results onto a single register-file write port.
// Loads wait in a small FIFO; a starvation counter forces one queue drain when the ALU hogs the port.
module wb_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int QDEPTH = 4,
    parameter int STARVE = 8,
    localparam int ADDR  = $clog2(DEPTH),
    localparam int CW    = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR-1:0]   alu_reg,
    input  logic [WIDTH-1:0]  alu_data,
    output logic              alu_stall,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR-1:0]   mem_reg,
    input  logic [WIDTH-1:0]  mem_data,
    output logic              wen,
    output logic [ADDR-1:0]   wreg,
    output logic [WIDTH-1:0]  wdata,
    output logic [CW-1:0]     qcount
);

    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] QFULL    = CW'(QDEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

    logic [ADDR+WIDTH-1:0] q_mem_r [QDEPTH];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rptr_r;
    logic [CW-1:0]         qcount_r;
    logic [SW-1:0]         starve_r;
    logic                  alu_stall_r;
    logic                  wen_r;
    logic [ADDR-1:0]       wreg_r;
    logic [WIDTH-1:0]      wdata_r;

    logic                  head_valid_s;
    logic [ADDR-1:0]       head_reg_s;
    logic [WIDTH-1:0]      head_data_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  sel_valid_s;
    logic [ADDR-1:0]       sel_reg_s;
    logic [WIDTH-1:0]      sel_data_s;
    logic [CW-1:0]         qcount_nxt_s;
    logic [SW-1:0]         starve_nxt_s;

    assign head_valid_s = (qcount_r != {CW{1'b0}});
    assign head_reg_s   = q_mem_r[rptr_r][ADDR+WIDTH-1:WIDTH];
    assign head_data_s  = q_mem_r[rptr_r][WIDTH-1:0];
    // Ready drops combinationally with reset so no load is accepted while held in reset.
    assign mem_ready    = reset && (qcount_r != QFULL);
    assign push_s       = mem_valid && mem_ready;

    assign alu_stall = alu_stall_r;
    assign wen       = wen_r;
    assign wreg      = wreg_r;
    assign wdata     = wdata_r;
    assign qcount    = qcount_r;

    // Source selection: forced drain, then ALU, then queue head.
    always_comb begin
        pop_s       = 1'b0;
        sel_valid_s = 1'b0;
        sel_reg_s   = alu_reg;
        sel_data_s  = alu_data;
        if (alu_stall_r) begin
            pop_s       = head_valid_s;
            sel_valid_s = head_valid_s;
            sel_reg_s   = head_reg_s;
            sel_data_s  = head_data_s;
        end else if (alu_valid) begin
            sel_valid_s = 1'b1;
        end else if (head_valid_s) begin
            pop_s       = 1'b1;
            sel_valid_s = 1'b1;
            sel_reg_s   = head_reg_s;
            sel_data_s  = head_data_s;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Occupancy and starvation bookkeeping for the next edge.
    always_comb begin
        qcount_nxt_s = qcount_r;
        case ({push_s, pop_s})
            2'b10:   qcount_nxt_s = qcount_r + CW'(1);
            2'b01:   qcount_nxt_s = qcount_r - CW'(1);
            default: qcount_nxt_s = qcount_r;
        endcase
        if (pop_s || !head_valid_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else begin
            starve_nxt_s = starve_r + SW'(1);
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r      <= {PW{1'b0}};
            rptr_r      <= {PW{1'b0}};
            qcount_r    <= {CW{1'b0}};
            starve_r    <= {SW{1'b0}};
            alu_stall_r <= 1'b0;
            wen_r       <= 1'b0;
            wreg_r      <= {ADDR{1'b0}};
            wdata_r     <= {WIDTH{1'b0}};
        end else begin
            if (push_s) wptr_r <= wptr_r + PW'(1);
            if (pop_s)  rptr_r <= rptr_r + PW'(1);
            qcount_r    <= qcount_nxt_s;
            starve_r    <= starve_nxt_s;
            alu_stall_r <= (starve_nxt_s == STARVE_C);
            wen_r       <= sel_valid_s && (sel_reg_s != {ADDR{1'b0}});
            if (sel_valid_s) begin
                wreg_r  <= sel_reg_s;
                wdata_r <= sel_data_s;
            end
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_mem_r[wptr_r] <= {mem_reg, mem_data};
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with default parameters; expectations are hand-computed per scenario.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  qcount;

    int tests = 0;
    int fails = 0;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .wen(wen), .wreg(wreg), .wdata(wdata), .qcount(qcount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL rst_wen got=%0h exp=0", wen); end
        tests++; if (wreg !== 5'd0) begin fails++; $display("FAIL rst_wreg got=%0h exp=0", wreg); end
        tests++; if (wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata got=%0h exp=0", wdata); end
        tests++; if (alu_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0h exp=0", alu_stall); end
        tests++; if (qcount !== 3'd0) begin fails++; $display("FAIL rst_qcount got=%0h exp=0", qcount); end
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%0h exp=0", mem_ready); end
        tick();
        reset = 1'b1;
        tick();
        tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got=%0h exp=1", mem_ready); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL alu_wen got=%0h exp=1", wen); end
        tests++; if (wreg !== 5'd5) begin fails++; $display("FAIL alu_wreg got=%0h exp=5", wreg); end
        tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_wdata got=%0h exp=deadbeef", wdata); end
        tick();
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL alu_wen_off got=%0h exp=0", wen); end
        tests++; if (wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_hold got=%0h exp=deadbeef", wdata); end
    endtask

    task automatic test_load();
        mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h12345678;
        tick();
        mem_valid = 1'b0;
        tests++; if (qcount !== 3'd1) begin fails++; $display("FAIL load_q1 got=%0h exp=1", qcount); end
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL load_early got=%0h exp=0", wen); end
        tick();
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL load_wen got=%0h exp=1", wen); end
        tests++; if (wreg !== 5'd7) begin fails++; $display("FAIL load_wreg got=%0h exp=7", wreg); end
        tests++; if (wdata !== 32'h12345678) begin fails++; $display("FAIL load_wdata got=%0h exp=12345678", wdata); end
        tests++; if (qcount !== 3'd0) begin fails++; $display("FAIL load_q0 got=%0h exp=0", qcount); end
        tick();
    endtask

    task automatic test_fill();
        alu_valid = 1'b1; alu_reg = 5'd10;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hC000 + 32'(i);
            mem_valid = 1'b1; mem_reg = 5'(i + 1); mem_data = 32'hA0 + 32'(i);
            tick();
            tests++; if (qcount !== 3'(i + 1)) begin fails++; $display("FAIL fill_q%0d got=%0h exp=%0h", i, qcount, i + 1); end
            tests++; if (wreg !== 5'd10 || wdata !== 32'hC000 + 32'(i)) begin fails++; $display("FAIL fill_alu%0d got=%0h/%0h exp=a/%0h", i, wreg, wdata, 32'hC000 + 32'(i)); end
        end
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%0h exp=0", mem_ready); end
        mem_reg = 5'd20; mem_data = 32'hBAD;
        tick();
        tests++; if (qcount !== 3'd4) begin fails++; $display("FAIL full_q got=%0h exp=4", qcount); end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (wen !== 1'b1 || wreg !== 5'(i + 1) || wdata !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, wen, wreg, wdata, i + 1, 32'hA0 + 32'(i)); end
            tests++; if (qcount !== 3'(3 - i)) begin fails++; $display("FAIL drain_q%0d got=%0h exp=%0h", i, qcount, 3 - i); end
        end
        tick();
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL drain_end got=%0h exp=0", wen); end
    endtask

    task automatic test_back_to_back();
        mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h33;
        tick();
        mem_reg = 5'd4; mem_data = 32'h44;
        tick();
        mem_valid = 1'b0;
        tests++; if (qcount !== 3'd1) begin fails++; $display("FAIL b2b_q got=%0h exp=1", qcount); end
        tests++; if (wen !== 1'b1 || wreg !== 5'd3) begin fails++; $display("FAIL b2b_w3 got=%0h/%0h exp=1/3", wen, wreg); end
        tick();
        tests++; if (wen !== 1'b1 || wreg !== 5'd4 || wdata !== 32'h44) begin fails++; $display("FAIL b2b_w4 got=%0h/%0h/%0h exp=1/4/44", wen, wreg, wdata); end
        tests++; if (qcount !== 3'd0) begin fails++; $display("FAIL b2b_q0 got=%0h exp=0", qcount); end
        tick();
    endtask

    task automatic test_starve();
        alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'h100;
        mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h99;
        tick();
        mem_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            alu_data = 32'h100 + 32'(k);
            tick();
            tests++; if (alu_stall !== (k == 8)) begin fails++; $display("FAIL starve_stall%0d got=%0h exp=%0h", k, alu_stall, k == 8); end
            tests++; if (wreg !== 5'd11 || wdata !== 32'h100 + 32'(k)) begin fails++; $display("FAIL starve_alu%0d got=%0h/%0h exp=b/%0h", k, wreg, wdata, 32'h100 + 32'(k)); end
        end
        alu_data = 32'hABCD;
        tick();
        tests++; if (wen !== 1'b1 || wreg !== 5'd9 || wdata !== 32'h99) begin fails++; $display("FAIL starve_head got=%0h/%0h/%0h exp=1/9/99", wen, wreg, wdata); end
        tests++; if (alu_stall !== 1'b0 || qcount !== 3'd0) begin fails++; $display("FAIL starve_clear got=%0h/%0h exp=0/0", alu_stall, qcount); end
        tick();
        alu_valid = 1'b0;
        tests++; if (wen !== 1'b1 || wreg !== 5'd11 || wdata !== 32'hABCD) begin fails++; $display("FAIL starve_held got=%0h/%0h/%0h exp=1/b/abcd", wen, wreg, wdata); end
        tick();
    endtask

    task automatic test_reg0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL r0_alu got=%0h exp=0", wen); end
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h66;
        tick();
        mem_valid = 1'b0;
        tests++; if (qcount !== 3'd1) begin fails++; $display("FAIL r0_push got=%0h exp=1", qcount); end
        tick();
        tests++; if (qcount !== 3'd0 || wen !== 1'b0) begin fails++; $display("FAIL r0_pop got=%0h/%0h exp=0/0", qcount, wen); end
    endtask

    task automatic test_async_reset();
        alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_reg = 5'(20 + i); mem_data = 32'hE0 + 32'(i);
            tick();
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        tests++; if (qcount !== 3'd3 || wen !== 1'b1) begin fails++; $display("FAIL pre_rst got=%0h/%0h exp=3/1", qcount, wen); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (qcount !== 3'd0) begin fails++; $display("FAIL arst_q got=%0h exp=0", qcount); end
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL arst_wen got=%0h exp=0", wen); end
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL arst_ready got=%0h exp=0", mem_ready); end
        tick();
        reset = 1'b1;
        #1;
        tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL arst_rel_ready got=%0h exp=1", mem_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (wen !== 1'b0 || qcount !== 3'd0) begin fails++; $display("FAIL arst_stale%0d got=%0h/%0h exp=0/0", i, wen, qcount); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_fill();
        test_back_to_back();
        test_starve();
        test_reg0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
